apb_qspi_host_bridge: RTL

//  APB completer that tunnels each 16-bit APB read/write over a quad-SPI link as host (SCK/CS_n driver).
//  It is the far end of the management QSPI device bridge: it lets a local APB requester (test harness or a

---
 rtl/apb_qspi_host_bridge_if.sv | 21 ++
 rtl/apb_qspi_host_bridge.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/apb_qspi_host_bridge_if.sv
// rtl/apb_qspi_host_bridge_if.sv - APB requester/completer signal bundle for the QSPI host bridge
interface apb_qspi_host_bridge_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [23:0] paddr;
  logic [15:0] pwdata;
  logic        pready;
  logic [15:0] prdata;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_qspi_host_bridge.sv
// rtl/apb_qspi_host_bridge.sv - APB completer tunnelling 16-bit accesses over a quad-SPI host link
module apb_qspi_host_bridge #(
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned DUMMY_CYCLES = 4,
  parameter logic [7:0]  OP_WRITE     = 8'h02,
  parameter logic [7:0]  OP_READ      = 8'h0B
) (
  input  logic                  pclk_i,
  input  logic                  preset_n_i,
  apb_qspi_host_bridge_if.slave apb,
  output logic                  qspi_sck_o,
  output logic                  qspi_cs_n_o,
  output logic [3:0]            qspi_dq_out_o,
  output logic                  qspi_dq_oe_o,
  input  logic [3:0]            qspi_dq_in_i
);
  localparam int unsigned N_WR     = 12;
  localparam int unsigned N_RD     = 12 + DUMMY_CYCLES;
  localparam int unsigned RX_START = 8 + DUMMY_CYCLES;
  localparam int unsigned HW       = $clog2(CLK_DIV + 1);
  localparam int unsigned NW       = $clog2(N_RD + 1);
  localparam int unsigned TW       = NW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ERROR, S_CS_SETUP, S_SHIFT, S_CS_HOLD, S_CS_IDLE, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d, hcnt_inc;
  logic [NW-1:0] nib_q, nib_d, nib_end;
  logic          half_q, half_d;
  logic          wr_q, wr_d;
  logic [23:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   rx_q, rx_d;
  logic [15:0]   prdata_q, prdata_d;
  logic          hcnt_last, tx_oe;
  logic [TW-1:0] tx_idx;
  logic [47:0]   frame, frame_sh;
  logic          sck, cs_n, oe, pready, pslverr;
  logic [3:0]    dq_out;

  assign hcnt_last = (hcnt_q == HW'(CLK_DIV - 1));
  assign hcnt_inc  = hcnt_last ? '0 : hcnt_q + 1'b1;
  assign nib_end   = wr_q ? NW'(N_WR - 1) : NW'(N_RD - 1);

  // During the low half of a period the next nibble is already on the wire (falling-edge launch).
  assign tx_idx   = TW'(nib_q) + TW'(half_q);
  assign frame    = {(wr_q ? OP_WRITE : OP_READ), addr_q, wdata_q};
  assign frame_sh = frame << {tx_idx, 2'b00};
  assign tx_oe    = wr_q || (nib_q < NW'(7)) || ((nib_q == NW'(7)) && !half_q);

  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    half_d   = half_q;
    nib_d    = nib_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rx_d     = rx_q;
    prdata_d = prdata_q;
    sck      = 1'b0;
    cs_n     = 1'b1;
    oe       = 1'b0;
    dq_out   = 4'h0;
    pready   = 1'b0;
    pslverr  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (apb.psel && apb.penable) begin
          wr_d    = apb.pwrite;
          addr_d  = apb.paddr;
          wdata_d = apb.pwdata;
          hcnt_d  = '0;
          half_d  = 1'b0;
          nib_d   = '0;
          if (apb.paddr[0]) begin
            prdata_d = '0;
            state_d  = S_ERROR;
          end else begin
            state_d  = S_CS_SETUP;
          end
        end
      end
      S_ERROR: begin
        pready  = 1'b1;
        pslverr = 1'b1;
        state_d = S_IDLE;
      end
      S_CS_SETUP: begin
        cs_n   = 1'b0;
        oe     = 1'b1;
        dq_out = frame_sh[47:44];
        hcnt_d = hcnt_inc;
        if (hcnt_last) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        cs_n   = 1'b0;
        sck    = ~half_q;
        oe     = tx_oe;
        dq_out = tx_oe ? frame_sh[47:44] : 4'h0;
        // Sample in the cycle that raises SCK, only once the dummy turnaround is over.
        if (!half_q && (hcnt_q == '0) && !wr_q && (nib_q >= NW'(RX_START)))
          rx_d = {rx_q[11:0], qspi_dq_in_i};
        hcnt_d = hcnt_inc;
        if (hcnt_last) begin
          half_d = ~half_q;
          if (half_q) begin
            if (nib_q == nib_end) state_d = S_CS_HOLD;
            else                  nib_d   = nib_q + 1'b1;
          end
        end
      end
      S_CS_HOLD: begin
        cs_n   = 1'b0;
        oe     = wr_q;
        hcnt_d = hcnt_inc;
        if (hcnt_last) state_d = S_CS_IDLE;
      end
      S_CS_IDLE: begin
        hcnt_d = hcnt_inc;
        if (hcnt_last) begin
          prdata_d = wr_q ? '0 : rx_q;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        pready  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      state_q  <= S_IDLE;
      hcnt_q   <= '0;
      half_q   <= 1'b0;
      nib_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rx_q     <= '0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      half_q   <= half_d;
      nib_q    <= nib_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rx_q     <= rx_d;
      prdata_q <= prdata_d;
    end
  end

  assign qspi_sck_o    = sck;
  assign qspi_cs_n_o   = cs_n;
  assign qspi_dq_out_o = dq_out;
  assign qspi_dq_oe_o  = oe;
  assign apb.pready    = pready;
  assign apb.pslverr   = pslverr;
  assign apb.prdata    = prdata_q;
endmodule
